posit_op_issuer: RTL

- Initiator-side sequencer for a posit_opgroup_block instance (DIVSQRT group by default).
- Accepts operation requests from an upstream valid/ready port and drives the unit's input handshake, collecting its output handshake.
- Buffers results in a response FIFO and returns them in issue order.
- Credit-limits issue so the unit's out_ready never has to drop; handles flush as a sequenced drain.

---
 rtl/posit_pkg.sv | 43 ++++
 rtl/posit_op_issuer_fifo.sv | 59 +++++
 rtl/posit_op_issuer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared posit types: formats, operations, status flags, plus the issuer's
// state encoding and default-width request/response records.
package posit_pkg;

   typedef enum logic [1:0] {POSIT8, POSIT16, POSIT32, POSIT64} posit_format_e;

   function automatic int unsigned posit_width(posit_format_e fmt);
      case (fmt)
         POSIT8:  return 8;
         POSIT16: return 16;
         POSIT32: return 32;
         default: return 64;
      endcase
   endfunction

   typedef enum logic [1:0] {ADD, MUL, DIV, SQRT} operation_e;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } status_t;

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} issuer_state_e;

   localparam int unsigned ISSUER_WIDTH     = posit_width(POSIT32);
   localparam int unsigned ISSUER_TAG_WIDTH = 4;

   typedef struct packed {
      operation_e                          op;
      logic [1:0][ISSUER_WIDTH-1:0]        operands;
      logic [ISSUER_TAG_WIDTH-1:0]         tag;
   } issue_req_t;

   typedef struct packed {
      logic [ISSUER_WIDTH-1:0]     result;
      status_t                     status;
      logic [ISSUER_TAG_WIDTH-1:0] tag;
   } rsp_t;

endpackage

// File: rtl/posit_op_issuer_fifo.sv
// Small synchronous FIFO with a combinational head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module posit_op_issuer_fifo #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clear_i,
   input  logic                  push_i,
   input  logic                  pop_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  empty_o
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0]      count_reg;
   logic                  full, do_push, do_pop;

   assign empty_o = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop_i && !empty_o && !clear_i;
   assign do_push = push_i && (!full || do_pop) && !clear_i;
   assign rdata_o = mem_reg[rd_ptr_reg];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_reg[i] <= '0;
      end else if (do_push) begin
         mem_reg[wr_ptr_reg] <= wdata_i;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (clear_i) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/posit_op_issuer.sv
// Credit-limited request sequencer for a posit op-group unit with in-order
// response buffering. Optional tag-order checking: POSIT_OP_ISSUER_TAG_CHECK_EN.
module posit_op_issuer
   import posit_pkg::*;
#(
   parameter int unsigned WIDTH     = posit_width(POSIT32),
   parameter int unsigned TAG_WIDTH = 4,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     flush_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  operation_e               req_op_i,
   input  logic [1:0][WIDTH-1:0]    req_operands_i,
   input  logic [TAG_WIDTH-1:0]     req_tag_i,
   output logic [1:0][WIDTH-1:0]    unit_operands_o,
   output operation_e               unit_op_o,
   output logic [TAG_WIDTH-1:0]     unit_tag_o,
   output logic                     unit_in_valid_o,
   input  logic                     unit_in_ready_i,
   output logic                     unit_flush_o,
   input  logic [WIDTH-1:0]         unit_result_i,
   input  status_t                  unit_status_i,
   input  logic [TAG_WIDTH-1:0]     unit_tag_i,
   input  logic                     unit_out_valid_i,
   output logic                     unit_out_ready_o,
   input  logic                     unit_busy_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [WIDTH-1:0]         rsp_result_o,
   output status_t                  rsp_status_o,
   output logic [TAG_WIDTH-1:0]     rsp_tag_o,
   output logic [$clog2(RSP_DEPTH):0] credit_o,
   output logic                     error_o
);
   localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;

   typedef struct packed {
      operation_e              op;
      logic [1:0][WIDTH-1:0]   operands;
      logic [TAG_WIDTH-1:0]    tag;
   } req_w_t;

   typedef struct packed {
      logic [WIDTH-1:0]     result;
      status_t              status;
      logic [TAG_WIDTH-1:0] tag;
   } rsp_w_t;

   issuer_state_e  state_reg, state_next;
   req_w_t         issue_reg;
   logic           issue_full_reg;
   logic [CW-1:0]  credit_reg;
   logic           unit_flush_reg;
   logic           run_reg;
   logic           flush_clear, unit_hs, req_accept, out_hs, rsp_pop, rsp_empty;
   rsp_w_t         rsp_push_data, rsp_head;

   assign flush_clear     = flush_i || (state_reg == FLUSH);
   assign unit_in_valid_o = issue_full_reg && (credit_reg < CW'(RSP_DEPTH));
   assign unit_hs         = unit_in_valid_o && unit_in_ready_i;
   assign req_accept      = req_valid_i && req_ready_o;
   assign out_hs          = unit_out_valid_i && unit_out_ready_o;
   assign rsp_valid_o     = !rsp_empty && (state_reg != FLUSH);
   assign rsp_pop         = rsp_valid_o && rsp_ready_i;

   assign unit_operands_o = issue_reg.operands;
   assign unit_op_o       = issue_reg.op;
   assign unit_tag_o      = issue_reg.tag;
   assign unit_flush_o    = unit_flush_reg;
   assign credit_o        = credit_reg;

   always_comb begin
      state_next       = state_reg;
      req_ready_o      = 1'b0;
      unit_out_ready_o = 1'b0;
      case (state_reg)
         IDLE, ACTIVE: begin
            // run_reg keeps the ready outputs low while reset is held.
            req_ready_o      = run_reg && (!issue_full_reg || unit_hs);
            unit_out_ready_o = run_reg;
            if (state_reg == IDLE) begin
               if (req_valid_i && req_ready_o) state_next = ACTIVE;
            end else if (credit_reg == '0 && !issue_full_reg && !(req_valid_i && req_ready_o)) begin
               state_next = IDLE;
            end
         end
         FLUSH: if (!unit_busy_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (flush_i) state_next = FLUSH;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg      <= IDLE;
         unit_flush_reg <= 1'b0;
         run_reg        <= 1'b0;
      end else begin
         state_reg      <= state_next;
         unit_flush_reg <= (state_next == FLUSH) && (state_reg != FLUSH);
         run_reg        <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_reg      <= '0;
         issue_full_reg <= 1'b0;
      end else if (flush_clear) begin
         issue_full_reg <= 1'b0;
      end else if (req_accept) begin
         issue_reg      <= '{op: req_op_i, operands: req_operands_i, tag: req_tag_i};
         issue_full_reg <= 1'b1;
      end else if (unit_hs) begin
         issue_full_reg <= 1'b0;
      end
   end

   // Credit covers in-flight plus buffered results, so a unit result always
   // finds FIFO space; the decrement saturates against stray unit outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         credit_reg <= '0;
      end else if (flush_clear) begin
         credit_reg <= '0;
      end else begin
         case ({unit_hs, rsp_pop})
            2'b10:   credit_reg <= credit_reg + 1'b1;
            2'b01:   if (credit_reg != '0) credit_reg <= credit_reg - 1'b1;
            default: credit_reg <= credit_reg;
         endcase
      end
   end

   assign rsp_push_data = '{result: unit_result_i, status: unit_status_i, tag: unit_tag_i};

   posit_op_issuer_fifo #(
      .DATA_WIDTH ($bits(rsp_w_t)),
      .DEPTH      (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_clear),
      .push_i  (out_hs),
      .pop_i   (rsp_pop),
      .wdata_i (rsp_push_data),
      .rdata_o (rsp_head),
      .empty_o (rsp_empty)
   );

   assign rsp_result_o = rsp_head.result;
   assign rsp_status_o = rsp_head.status;
   assign rsp_tag_o    = rsp_head.tag;

`ifdef POSIT_OP_ISSUER_TAG_CHECK_EN
   logic [TAG_WIDTH-1:0] exp_tag;
   logic                 tag_empty;
   logic                 error_reg;

   posit_op_issuer_fifo #(
      .DATA_WIDTH (TAG_WIDTH),
      .DEPTH      (RSP_DEPTH)
   ) u_tag_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clear_i (flush_clear),
      .push_i  (unit_hs),
      .pop_i   (out_hs),
      .wdata_i (unit_tag_o),
      .rdata_o (exp_tag),
      .empty_o (tag_empty)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         error_reg <= 1'b0;
      end else if (out_hs && !flush_clear && (tag_empty || exp_tag != unit_tag_i)) begin
         error_reg <= 1'b1;
      end
   end

   assign error_o = error_reg;
`else
   assign error_o = 1'b0;
`endif

endmodule
